// File: rtl/spi_reg_frontend_if.sv
// Register-access bus between the SPI front end and the peripheral strobe logic.
// The slave modport is the front end's view; master is the host/peripheral side.
interface spi_reg_frontend_if #(
    parameter int ADDR_W = 6,
    parameter int REG_W  = 32
);
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_data_o;
    logic [REG_W-1:0]  reg_data_i;
    logic              rd_ready;
    logic              reg_addr_v;
    logic              reg_data_o_dv;
    logic              reg_rw;
    logic [1:0]        txn_width;
    logic [7:0]        status;

    modport slave (
        input  spi_cs_n, spi_clk, spi_mosi, reg_data_i, rd_ready, status,
        output spi_miso, reg_addr, reg_data_o, reg_addr_v, reg_data_o_dv, reg_rw, txn_width
    );

    modport master (
        output spi_cs_n, spi_clk, spi_mosi, reg_data_i, rd_ready, status,
        input  spi_miso, reg_addr, reg_data_o, reg_addr_v, reg_data_o_dv, reg_rw, txn_width
    );
endinterface

// File: rtl/spi_reg_frontend.sv
// SPI mode-0 slave that turns {rw,width},{addr},data frames into register
// write strobes / read requests and shifts status and read data back on MISO.
module spi_reg_frontend #(
    parameter int ADDR_W = 6,
    parameter int REG_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_frontend_if.slave  bus
);
    localparam int IDX_W = $clog2(REG_W);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t            state_reg;
    logic              spi_clk_reg;
    logic [5:0]        bit_cnt_reg;
    logic [7:0]        hdr_sr_reg;
    logic [REG_W-1:0]  rx_sr_reg;
    logic [REG_W-1:0]  tx_data_reg;
    logic              captured_reg;
    logic              miso_reg;
    logic              reg_rw_reg;
    logic [1:0]        width_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              addr_v_reg;
    logic [REG_W-1:0]  data_o_reg;
    logic              dv_reg;

    logic              rise;
    logic              fall;
    logic [5:0]        n_bits;
    logic              last_bit;
    logic [7:0]        hdr_next;
    logic [REG_W-1:0]  rx_next;
    logic [REG_W-1:0]  width_mask;
    logic [IDX_W-1:0]  tx_idx;
    logic              rd_take;

    assign rise     = bus.spi_clk & ~spi_clk_reg;
    assign fall     = ~bus.spi_clk & spi_clk_reg;
    assign n_bits   = (width_reg == 2'b00) ? 6'd8 : (width_reg == 2'b01) ? 6'd16 : 6'd32;
    assign last_bit = (bit_cnt_reg == n_bits - 6'd1);
    assign hdr_next = {hdr_sr_reg[6:0], bus.spi_mosi};
    assign rx_next  = {rx_sr_reg[REG_W-2:0], bus.spi_mosi};
    // Bit position in the captured word for the data bit set up by this fall.
    assign tx_idx   = IDX_W'(n_bits - 6'd1 - bit_cnt_reg);
    assign rd_take  = ~reg_rw_reg & addr_v_reg & bus.rd_ready;

    for (genvar gi = 0; gi < REG_W; gi++) begin : g_mask
        assign width_mask[gi] = (gi < int'(n_bits));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            spi_clk_reg  <= 1'b0;
            bit_cnt_reg  <= '0;
            hdr_sr_reg   <= '0;
            rx_sr_reg    <= '0;
            tx_data_reg  <= '0;
            captured_reg <= 1'b0;
            miso_reg     <= 1'b0;
            reg_rw_reg   <= 1'b0;
            width_reg    <= 2'b00;
            addr_reg     <= '0;
            addr_v_reg   <= 1'b0;
            data_o_reg   <= '0;
            dv_reg       <= 1'b0;
        end else begin
            spi_clk_reg <= bus.spi_clk;
            dv_reg      <= 1'b0;
            // Deselect wins over everything, including a coincident final data edge.
            if (bus.spi_cs_n) begin
                state_reg    <= IDLE;
                bit_cnt_reg  <= '0;
                addr_v_reg   <= 1'b0;
                captured_reg <= 1'b0;
                miso_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg    <= HDR;
                        bit_cnt_reg  <= '0;
                        hdr_sr_reg   <= '0;
                        rx_sr_reg    <= '0;
                        captured_reg <= 1'b0;
                        miso_reg     <= 1'b0;
                    end
                    HDR: begin
                        if (rise) begin
                            hdr_sr_reg  <= hdr_next;
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            if (bit_cnt_reg == 6'd7) begin
                                reg_rw_reg <= hdr_next[7];
                                width_reg  <= hdr_next[1:0];
                            end
                            if (bit_cnt_reg == 6'd15) begin
                                addr_reg    <= hdr_next[ADDR_W-1:0];
                                addr_v_reg  <= 1'b1;
                                bit_cnt_reg <= '0;
                                state_reg   <= DATA;
                            end
                        end else if (fall) begin
                            // Falls after rises 8..15 set up byte1, which carries status.
                            miso_reg <= (bit_cnt_reg >= 6'd8) ? bus.status[~bit_cnt_reg[2:0]] : 1'b0;
                        end
                    end
                    DATA: begin
                        if (rd_take) begin
                            tx_data_reg  <= bus.reg_data_i & width_mask;
                            captured_reg <= 1'b1;
                            addr_v_reg   <= 1'b0;
                        end
                        if (rise) begin
                            rx_sr_reg   <= rx_next;
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            if (last_bit) begin
                                state_reg <= DONE;
                                miso_reg  <= 1'b0;
                                if (reg_rw_reg) begin
                                    data_o_reg <= rx_next & width_mask;
                                    dv_reg     <= 1'b1;
                                end
                            end
                        end else if (fall) begin
                            miso_reg <= captured_reg ? tx_data_reg[tx_idx] : 1'b0;
                        end
                    end
                    DONE: begin
                        if (rd_take) begin
                            addr_v_reg <= 1'b0;
                        end
                        miso_reg <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.spi_miso      = miso_reg;
    assign bus.reg_addr      = addr_reg;
    assign bus.reg_data_o    = data_o_reg;
    assign bus.reg_addr_v    = addr_v_reg;
    assign bus.reg_data_o_dv = dv_reg;
    assign bus.reg_rw        = reg_rw_reg;
    assign bus.txn_width     = width_reg;
endmodule

// File: tb/tb_spi_reg_frontend.sv
// Drives directed and random SPI frames into spi_reg_frontend and checks
// strobes, held outputs and MISO against a frame-level reference model.
module tb_spi_reg_frontend;
    localparam int HALF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_reg_frontend_if bus ();

    spi_reg_frontend dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          dv_total = 0;
    logic [31:0] dv_data_last = '0;
    logic        rd_armed = 1'b0;
    int          rd_delay = 0;
    logic [31:0] rd_value = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.reg_data_o_dv === 1'b1) begin
            dv_total++;
            dv_data_last = bus.reg_data_o;
        end
    end

    // Peripheral model: answers a pending read after rd_delay cycles.
    initial begin : responder
        bus.rd_ready   = 1'b0;
        bus.reg_data_i = '0;
        forever begin
            @(negedge clk);
            if (rd_armed && bus.reg_addr_v === 1'b1 && bus.reg_rw === 1'b0) begin
                for (int k = 0; k < rd_delay; k++) begin
                    @(negedge clk);
                    check_val("addr_v_held", bus.reg_addr_v, 1);
                end
                bus.reg_data_i = rd_value;
                bus.rd_ready   = 1'b1;
                @(negedge clk);
                bus.rd_ready   = 1'b0;
                check_val("addr_v_clear", bus.reg_addr_v, 0);
                rd_armed = 1'b0;
            end
        end
    end

    task automatic spi_bit(input logic b, input int extra_high, output logic m);
        bus.spi_mosi = b;
        repeat (HALF) @(negedge clk);
        m = bus.spi_miso;
        bus.spi_clk = 1'b1;
        repeat (HALF + extra_high) @(negedge clk);
        bus.spi_clk = 1'b0;
    endtask

    task automatic do_frame(input logic rw, input logic [1:0] w, input logic [5:0] addr,
                            input logic [31:0] data, input logic [31:0] rdv, input int rdd,
                            input logic [7:0] stat, input int n_data, input int rst_at,
                            input logic coincide);
        int          n;
        logic [31:0] mask;
        logic [15:0] hdr;
        logic [15:0] hdr_miso;
        logic [31:0] rx_word;
        logic        extra_or;
        logic        m;
        logic        b;
        int          dv0;
        logic        aborted;
        logic        full;
        n        = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
        mask     = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        hdr      = {rw, 5'b0, w, 2'b00, addr};
        dv0      = dv_total;
        aborted  = 1'b0;
        hdr_miso = '0;
        rx_word  = '0;
        extra_or = 1'b0;
        $display("frame rw=%0d w=%0d addr=0x%02h data=0x%08h rd=0x%08h status=0x%02h bits=%0d rst_at=%0d coincide=%0d",
                 rw, w, addr, data & mask, rdv & mask, stat, n_data, rst_at, coincide);
        bus.status = stat;
        if (!rw) begin
            rd_value = rdv & mask;
            rd_delay = rdd;
            rd_armed = 1'b1;
        end
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            spi_bit(hdr[15-i], (i == 15 && !rw) ? 10 : 0, m);
            hdr_miso = {hdr_miso[14:0], m};
        end
        check_val("hdr_addr", bus.reg_addr, addr);
        check_val("hdr_rw", bus.reg_rw, rw);
        check_val("hdr_width", bus.txn_width, w);
        for (int i = 0; i < n_data; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_val("rst_ctrl", {bus.spi_miso, bus.reg_addr_v, bus.reg_data_o_dv, bus.reg_rw, bus.txn_width}, 0);
                check_val("rst_addr", bus.reg_addr, 0);
                check_val("rst_data_o", bus.reg_data_o, 0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            b = (i < n) ? data[n-1-i] : 1'($urandom_range(0, 1));
            if (coincide && i == n - 1) begin
                bus.spi_mosi = b;
                repeat (HALF) @(negedge clk);
                bus.spi_clk  = 1'b1;
                bus.spi_cs_n = 1'b1;
                repeat (HALF) @(negedge clk);
                bus.spi_clk  = 1'b0;
                aborted = 1'b1;
                break;
            end
            spi_bit(b, 0, m);
            if (i < n) rx_word = {rx_word[30:0], m};
            else extra_or = extra_or | m;
        end
        repeat (3) @(negedge clk);
        if (!aborted && rw) check_val("addr_v_wr_held", bus.reg_addr_v, 1);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("addr_v_idle", bus.reg_addr_v, 0);
        check_val("miso_idle", bus.spi_miso, 0);
        check_val("hdr_miso", hdr_miso, {8'h00, stat});
        full = !aborted && (n_data >= n);
        if (rw) begin
            check_val("dv_count", dv_total - dv0, full ? 1 : 0);
            if (full) begin
                check_val("dv_data", dv_data_last, data & mask);
                check_val("data_o_held", bus.reg_data_o, data & mask);
            end
        end else if (full) begin
            check_val("rd_miso", rx_word, rdv & mask);
        end
        if (full && n_data > n) check_val("done_miso", extra_or, 0);
        rd_armed = 1'b0;
    endtask

    initial begin : main
        bus.spi_cs_n = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.status   = 8'h00;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_val("reset_ctrl", {bus.spi_miso, bus.reg_addr_v, bus.reg_data_o_dv, bus.reg_rw, bus.txn_width}, 0);
        check_val("reset_addr", bus.reg_addr, 0);
        check_val("reset_data_o", bus.reg_data_o, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_frame(1'b1, 2'b10, 6'h05, 32'hDEADBEEF, 32'h0, 0, 8'h5A, 32, -1, 1'b0);
        do_frame(1'b1, 2'b00, 6'h3F, 32'h000000A5, 32'h0, 0, 8'h5A, 8, -1, 1'b0);
        do_frame(1'b0, 2'b01, 6'h02, 32'h0, 32'h00001234, 3, 8'h5A, 16, -1, 1'b0);
        do_frame(1'b1, 2'b10, 6'h11, 32'hCAFEF00D, 32'h0, 0, 8'hC3, 20, -1, 1'b0);
        do_frame(1'b1, 2'b11, 6'h12, 32'h13579BDF, 32'h0, 0, 8'h81, 32, -1, 1'b0);
        do_frame(1'b0, 2'b10, 6'h2A, 32'h0, 32'h89ABCDEF, 0, 8'h3C, 32, 4, 1'b0);
        do_frame(1'b1, 2'b00, 6'h07, 32'h0000003C, 32'h0, 0, 8'hF0, 48, -1, 1'b0);
        do_frame(1'b1, 2'b01, 6'h09, 32'h0000BEEF, 32'h0, 0, 8'h0F, 16, -1, 1'b1);
        do_frame(1'b0, 2'b11, 6'h15, 32'h0, 32'hA5A55A5A, 5, 8'h99, 40, -1, 1'b0);

        for (int t = 0; t < 16; t++) begin
            logic [1:0] w;
            int         n;
            w = 2'($urandom_range(0, 3));
            n = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
            do_frame(1'($urandom_range(0, 1)), w, 6'($urandom), $urandom, $urandom,
                     $urandom_range(0, 6), 8'($urandom), n + $urandom_range(0, 4), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
